// File: rtl/tm_run_ctrl_pkg.sv
// Shared types for the timing-model run controller: clock bundle, debug
// start/stop encoding, host run commands and controller states.
package tm_run_ctrl_pkg;

    localparam int DEF_BUDGET_W = 32;
    localparam int DEF_DRAIN_CYC = 8;
    localparam int DEF_CNT_W = 64;

    typedef struct packed {
        logic clk;
    } iu_clk_type;

    typedef enum logic [1:0] {
        TM_DBG_NOP   = 2'd0,
        TM_DBG_START = 2'd1,
        TM_DBG_STOP  = 2'd2
    } tm_dbg_ctrl_type;

    typedef enum logic [2:0] {
        RC_NOP   = 3'd0,
        RC_START = 3'd1,
        RC_STOP  = 3'd2,
        RC_STEP  = 3'd3,
        RC_CLEAR = 3'd4
    } tm_runctl_cmd_type;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } tm_runctl_state_type;

    // Target cycles only count while the model is (or may still be) executing.
    function automatic logic counts_target(input tm_runctl_state_type s);
        return (s == RUN) || (s == DRAIN);
    endfunction

    function automatic logic accepts_start(input tm_runctl_state_type s);
        return (s == IDLE) || (s == HALT);
    endfunction

endpackage

// File: rtl/tm_cycle_counter.sv
// Wrapping cycle counter with synchronous clear; clear beats increment.
module tm_cycle_counter
    import tm_run_ctrl_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  iu_clk_type        gclk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clr,
    output logic [CNT_W-1:0]  value
);

    logic [CNT_W-1:0] value_q;
    logic [CNT_W-1:0] value_d;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            value_d = value_q + CNT_W'(1);
        end
    end

    always_ff @(posedge gclk.clk) begin
        if (rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/tm_run_ctrl.sv
// Run controller: turns host debug commands into registered start/stop pulses
// for the timing model, waits out pipeline drain, and keeps cycle counters.
module tm_run_ctrl
    import tm_run_ctrl_pkg::*;
#(
    parameter int BUDGET_W  = DEF_BUDGET_W,
    parameter int DRAIN_CYC = DEF_DRAIN_CYC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  iu_clk_type           gclk,
    input  logic                 rst,
    input  tm_runctl_cmd_type    cmd,
    input  logic [BUDGET_W-1:0]  budget,
    input  logic                 budget_we,
    input  logic                 tick,
    input  logic                 tm_running,
    output tm_dbg_ctrl_type      tm_ctrl,
    output tm_runctl_state_type  state,
    output logic                 done,
    output logic [CNT_W-1:0]     target_cycles,
    output logic [CNT_W-1:0]     host_cycles
);

    localparam int DRAIN_W = (DRAIN_CYC < 1) ? 1 : $clog2(DRAIN_CYC + 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYC);

    tm_runctl_state_type  state_q, state_d;
    tm_dbg_ctrl_type      tm_ctrl_q, tm_ctrl_d;
    logic                 done_q, done_d;
    logic [BUDGET_W-1:0]  budget_q, budget_d;
    logic [BUDGET_W-1:0]  remaining_q, remaining_d;
    logic [DRAIN_W-1:0]   drain_cnt_q, drain_cnt_d;

    logic stop_req;
    logic budget_expired;
    logic target_inc;
    logic counters_clr;

    assign stop_req       = (cmd == RC_STOP);
    assign budget_expired = tick && (remaining_q == BUDGET_W'(1));
    assign target_inc     = tick && counts_target(state_q);
    assign counters_clr   = (cmd == RC_CLEAR);

    // remaining==0 means free-run: it is never decremented and never expires.
    always_comb begin
        state_d     = state_q;
        tm_ctrl_d   = TM_DBG_NOP;
        done_d      = 1'b0;
        budget_d    = budget_we ? budget : budget_q;
        remaining_d = remaining_q;
        drain_cnt_d = drain_cnt_q;

        case (state_q)
            IDLE, HALT: begin
                if (cmd == RC_START) begin
                    state_d     = RUN;
                    remaining_d = budget_q;
                    tm_ctrl_d   = TM_DBG_START;
                end else if (cmd == RC_STEP) begin
                    state_d     = RUN;
                    remaining_d = BUDGET_W'(1);
                    tm_ctrl_d   = TM_DBG_START;
                end
            end
            RUN: begin
                if (stop_req || budget_expired) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                    tm_ctrl_d   = TM_DBG_STOP;
                end else if (tick && (remaining_q > BUDGET_W'(1))) begin
                    remaining_d = remaining_q - BUDGET_W'(1);
                end
            end
            DRAIN: begin
                // Any sign of life from the pipeline restarts the quiet window.
                if (tm_running) begin
                    drain_cnt_d = DRAIN_LOAD;
                end else if (drain_cnt_q <= DRAIN_W'(1)) begin
                    state_d = HALT;
                    done_d  = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Reset issues no stop pulse: the timing model shares rst and stops itself.
    always_ff @(posedge gclk.clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tm_ctrl_q   <= TM_DBG_NOP;
            done_q      <= 1'b0;
            budget_q    <= '0;
            remaining_q <= '0;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            tm_ctrl_q   <= tm_ctrl_d;
            done_q      <= done_d;
            budget_q    <= budget_d;
            remaining_q <= remaining_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    tm_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_target_cnt (
        .gclk  (gclk),
        .rst   (rst),
        .inc   (target_inc),
        .clr   (counters_clr),
        .value (target_cycles)
    );

    tm_cycle_counter #(
        .CNT_W (CNT_W)
    ) u_host_cnt (
        .gclk  (gclk),
        .rst   (rst),
        .inc   (tm_running),
        .clr   (counters_clr),
        .value (host_cycles)
    );

    assign tm_ctrl = tm_ctrl_q;
    assign state   = state_q;
    assign done    = done_q;

endmodule

// File: tb/tb_tm_run_ctrl.sv
// Directed bench for tm_run_ctrl: budgeted runs, free-run, single step,
// stop/expiry collision, drain reloads, reset mid-run and counter clear.
module tb_tm_run_ctrl;
    import tm_run_ctrl_pkg::*;

    iu_clk_type           gclk;
    logic                 rst;
    tm_runctl_cmd_type    cmd;
    logic [31:0]          budget;
    logic                 budget_we;
    logic                 tick;
    logic                 tm_running;
    tm_dbg_ctrl_type      tm_ctrl;
    tm_runctl_state_type  state;
    logic                 done;
    logic [63:0]          target_cycles;
    logic [63:0]          host_cycles;

    int errors = 0;
    int checks = 0;
    int startCount = 0;
    int stopCount = 0;

    tm_run_ctrl #(
        .BUDGET_W  (32),
        .DRAIN_CYC (8),
        .CNT_W     (64)
    ) dut (
        .gclk          (gclk),
        .rst           (rst),
        .cmd           (cmd),
        .budget        (budget),
        .budget_we     (budget_we),
        .tick          (tick),
        .tm_running    (tm_running),
        .tm_ctrl       (tm_ctrl),
        .state         (state),
        .done          (done),
        .target_cycles (target_cycles),
        .host_cycles   (host_cycles)
    );

    initial gclk.clk = 1'b0;
    always #5 gclk.clk = ~gclk.clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one cycle of inputs, samples 1ns after the edge, then returns to idle inputs.
    task automatic applyStimulus(input tm_runctl_cmd_type c, input logic t,
                                 input logic bwe, input logic [31:0] bval);
        cmd       = c;
        tick      = t;
        budget_we = bwe;
        budget    = bval;
        @(posedge gclk.clk);
        #1;
        cmd       = RC_NOP;
        tick      = 1'b0;
        budget_we = 1'b0;
        budget    = '0;
        if (tm_ctrl == TM_DBG_START) startCount++;
        if (tm_ctrl == TM_DBG_STOP) stopCount++;
    endtask

    task automatic waitHalt(input string tag, input int expCycles);
        int n = 0;
        while (state !== HALT && n < 40) begin
            applyStimulus(RC_NOP, 1'b0, 1'b0, 32'd0);
            n++;
        end
        checkOutput({tag, "_halt_state"}, 64'(state), 64'(HALT));
        checkOutput({tag, "_drain_len"}, 64'(n), 64'(expCycles));
        checkOutput({tag, "_done_pulse"}, 64'(done), 64'd1);
        applyStimulus(RC_NOP, 1'b0, 1'b0, 32'd0);
        checkOutput({tag, "_done_clear"}, 64'(done), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        cmd        = RC_NOP;
        budget     = '0;
        budget_we  = 1'b0;
        tick       = 1'b0;
        tm_running = 1'b0;

        applyStimulus(RC_NOP, 1'b0, 1'b0, 32'd0);
        applyStimulus(RC_NOP, 1'b0, 1'b0, 32'd0);
        rst = 1'b0;
        checkOutput("rst_state", 64'(state), 64'(IDLE));
        checkOutput("rst_ctrl", 64'(tm_ctrl), 64'(TM_DBG_NOP));
        checkOutput("rst_done", 64'(done), 64'd0);
        checkOutput("rst_target", target_cycles, 64'd0);
        checkOutput("rst_host", host_cycles, 64'd0);

        $display("[TB] test 1: budget 3 run");
        applyStimulus(RC_NOP, 1'b0, 1'b1, 32'd3);
        applyStimulus(RC_START, 1'b0, 1'b0, 32'd0);
        checkOutput("t1_start_pulse", 64'(tm_ctrl), 64'(TM_DBG_START));
        checkOutput("t1_state_run", 64'(state), 64'(RUN));
        tm_running = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            for (int i = 0; i < 4; i++)
                applyStimulus(RC_NOP, 1'b0, (k == 2 && i == 0), 32'd20);
            applyStimulus(RC_NOP, 1'b1, 1'b0, 32'd0);
            if (k < 3) begin
                checkOutput("t1_mid_state", 64'(state), 64'(RUN));
                checkOutput("t1_mid_ctrl", 64'(tm_ctrl), 64'(TM_DBG_NOP));
            end
        end
        checkOutput("t1_stop_pulse", 64'(tm_ctrl), 64'(TM_DBG_STOP));
        checkOutput("t1_state_drain", 64'(state), 64'(DRAIN));
        checkOutput("t1_target", target_cycles, 64'd3);
        checkOutput("t1_host", host_cycles, 64'd15);
        tm_running = 1'b0;
        waitHalt("t1", 8);
        checkOutput("t1_stop_count", 64'(stopCount), 64'd1);

        $display("[TB] test 2: free-run then stop");
        applyStimulus(RC_CLEAR, 1'b0, 1'b1, 32'd0);
        checkOutput("t2_clr_target", target_cycles, 64'd0);
        checkOutput("t2_clr_host", host_cycles, 64'd0);
        stopCount = 0;
        applyStimulus(RC_START, 1'b0, 1'b0, 32'd0);
        checkOutput("t2_start_pulse", 64'(tm_ctrl), 64'(TM_DBG_START));
        tm_running = 1'b1;
        for (int i = 0; i < 100; i++)
            applyStimulus(RC_NOP, 1'b1, 1'b0, 32'd0);
        checkOutput("t2_still_run", 64'(state), 64'(RUN));
        checkOutput("t2_no_autostop", 64'(stopCount), 64'd0);
        applyStimulus(RC_STOP, 1'b0, 1'b0, 32'd0);
        checkOutput("t2_stop_pulse", 64'(tm_ctrl), 64'(TM_DBG_STOP));
        checkOutput("t2_state_drain", 64'(state), 64'(DRAIN));
        checkOutput("t2_target", target_cycles, 64'd100);
        checkOutput("t2_host", host_cycles, 64'd101);
        tm_running = 1'b0;
        waitHalt("t2", 8);
        checkOutput("t2_stop_count", 64'(stopCount), 64'd1);
        applyStimulus(RC_STOP, 1'b0, 1'b0, 32'd0);
        checkOutput("t2_halt_stop_ign", 64'(tm_ctrl), 64'(TM_DBG_NOP));
        checkOutput("t2_halt_stays", 64'(state), 64'(HALT));

        $display("[TB] test 3: single step");
        applyStimulus(RC_CLEAR, 1'b0, 1'b1, 32'd50);
        applyStimulus(RC_STEP, 1'b0, 1'b0, 32'd0);
        checkOutput("t3_step_start", 64'(tm_ctrl), 64'(TM_DBG_START));
        checkOutput("t3_state_run", 64'(state), 64'(RUN));
        tm_running = 1'b1;
        applyStimulus(RC_NOP, 1'b1, 1'b0, 32'd0);
        checkOutput("t3_step_stop", 64'(tm_ctrl), 64'(TM_DBG_STOP));
        checkOutput("t3_state_drain", 64'(state), 64'(DRAIN));
        checkOutput("t3_target_one", target_cycles, 64'd1);
        applyStimulus(RC_NOP, 1'b1, 1'b0, 32'd0);
        checkOutput("t3_late_tick", target_cycles, 64'd2);
        tm_running = 1'b0;
        waitHalt("t3", 8);
        stopCount = 0;
        applyStimulus(RC_START, 1'b0, 1'b0, 32'd0);
        checkOutput("t3_restart", 64'(tm_ctrl), 64'(TM_DBG_START));
        tm_running = 1'b1;
        for (int i = 0; i < 49; i++)
            applyStimulus(RC_NOP, 1'b1, 1'b0, 32'd0);
        checkOutput("t3_budget50_run", 64'(state), 64'(RUN));
        checkOutput("t3_budget50_nostop", 64'(stopCount), 64'd0);
        applyStimulus(RC_NOP, 1'b1, 1'b0, 32'd0);
        checkOutput("t3_budget50_stop", 64'(tm_ctrl), 64'(TM_DBG_STOP));
        checkOutput("t3_target_52", target_cycles, 64'd52);
        tm_running = 1'b0;
        waitHalt("t3b", 8);

        $display("[TB] test 4: stop collides with expiry");
        applyStimulus(RC_CLEAR, 1'b0, 1'b1, 32'd2);
        startCount = 0;
        stopCount = 0;
        applyStimulus(RC_START, 1'b0, 1'b0, 32'd0);
        tm_running = 1'b1;
        applyStimulus(RC_NOP, 1'b1, 1'b0, 32'd0);
        checkOutput("t4_after_tick1", 64'(state), 64'(RUN));
        applyStimulus(RC_STOP, 1'b1, 1'b0, 32'd0);
        checkOutput("t4_stop_pulse", 64'(tm_ctrl), 64'(TM_DBG_STOP));
        checkOutput("t4_state_drain", 64'(state), 64'(DRAIN));
        checkOutput("t4_target", target_cycles, 64'd2);
        applyStimulus(RC_START, 1'b0, 1'b0, 32'd0);
        checkOutput("t4_start_ignored", 64'(tm_ctrl), 64'(TM_DBG_NOP));
        checkOutput("t4_still_drain", 64'(state), 64'(DRAIN));
        applyStimulus(RC_NOP, 1'b0, 1'b0, 32'd0);
        checkOutput("t4_stop_count", 64'(stopCount), 64'd1);
        checkOutput("t4_start_count", 64'(startCount), 64'd1);
        tm_running = 1'b0;
        waitHalt("t4", 8);

        $display("[TB] test 5: drain reload");
        applyStimulus(RC_CLEAR, 1'b0, 1'b1, 32'd0);
        applyStimulus(RC_START, 1'b0, 1'b0, 32'd0);
        tm_running = 1'b1;
        for (int i = 0; i < 3; i++)
            applyStimulus(RC_NOP, 1'b0, 1'b0, 32'd0);
        applyStimulus(RC_STOP, 1'b0, 1'b0, 32'd0);
        checkOutput("t5_state_drain", 64'(state), 64'(DRAIN));
        tm_running = 1'b0;
        for (int i = 0; i < 3; i++)
            applyStimulus(RC_NOP, 1'b0, 1'b0, 32'd0);
        tm_running = 1'b1;
        for (int i = 0; i < 2; i++)
            applyStimulus(RC_NOP, 1'b0, 1'b0, 32'd0);
        tm_running = 1'b0;
        for (int i = 0; i < 3; i++)
            applyStimulus(RC_NOP, 1'b0, 1'b0, 32'd0);
        checkOutput("t5_drain_hold", 64'(state), 64'(DRAIN));
        tm_running = 1'b1;
        applyStimulus(RC_NOP, 1'b0, 1'b0, 32'd0);
        tm_running = 1'b0;
        waitHalt("t5", 8);
        checkOutput("t5_host", host_cycles, 64'd7);

        $display("[TB] test 6: reset mid-run and clear with tick");
        applyStimulus(RC_START, 1'b0, 1'b0, 32'd0);
        tm_running = 1'b1;
        for (int i = 0; i < 7; i++)
            applyStimulus(RC_NOP, 1'b1, 1'b0, 32'd0);
        checkOutput("t6_target7", target_cycles, 64'd7);
        rst = 1'b1;
        applyStimulus(RC_STOP, 1'b1, 1'b0, 32'd0);
        rst = 1'b0;
        tm_running = 1'b0;
        checkOutput("t6_rst_state", 64'(state), 64'(IDLE));
        checkOutput("t6_rst_target", target_cycles, 64'd0);
        checkOutput("t6_rst_host", host_cycles, 64'd0);
        checkOutput("t6_rst_ctrl", 64'(tm_ctrl), 64'(TM_DBG_NOP));
        checkOutput("t6_rst_done", 64'(done), 64'd0);
        applyStimulus(RC_START, 1'b0, 1'b0, 32'd0);
        checkOutput("t6_start", 64'(tm_ctrl), 64'(TM_DBG_START));
        tm_running = 1'b1;
        for (int i = 0; i < 3; i++)
            applyStimulus(RC_NOP, 1'b1, 1'b0, 32'd0);
        checkOutput("t6_target3", target_cycles, 64'd3);
        applyStimulus(RC_CLEAR, 1'b1, 1'b0, 32'd0);
        checkOutput("t6_clr_tick_target", target_cycles, 64'd0);
        checkOutput("t6_clr_host", host_cycles, 64'd0);
        applyStimulus(RC_NOP, 1'b1, 1'b0, 32'd0);
        checkOutput("t6_tick_after_clr", target_cycles, 64'd1);
        applyStimulus(RC_STOP, 1'b0, 1'b0, 32'd0);
        checkOutput("t6_stop", 64'(tm_ctrl), 64'(TM_DBG_STOP));
        tm_running = 1'b0;
        waitHalt("t6", 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
